// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter peripheral: FSM encodings,
// register offsets and STATUS bit positions.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    // STATUS only has a 4-bit count field; deeper FIFOs report 15.
    function automatic logic [3:0] sat_count(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// Pop is ignored when empty, so a push into an empty FIFO is never bypassed.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO, bit-timing FSM
// and a registered level IRQ raised when the FIFO has drained and the line is idle.
module uart_tx_dev
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    state;
    logic [15:0]   divisor;
    logic [15:0]   bit_div;
    logic [15:0]   bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tx_en;
    logic          irq_en;
    logic          overflow;

    logic          wr_data;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] count;
    logic          busy;
    logic          bit_end;
    logic          unused_bits;

    assign unused_bits = ^{Addr[31:4], Din[31:16]};

    assign wr_data = WE && (Addr[3:2] == REG_DATA);
    assign busy    = (state != ST_IDLE);
    assign bit_end = (bit_cnt == bit_div - 16'd1);
    // A pop happens from IDLE, or at the end of a stop bit for back-to-back frames.
    assign pop     = tx_en && !empty && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
    assign push    = wr_data && (!full || pop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .din   (Din[7:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divisor  <= 16'(DIV_RESET);
            tx_en    <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (WE && (Addr[3:2] == REG_DIVISOR)) begin
                divisor <= (Din[15:0] == 16'd0) ? 16'd1 : Din[15:0];
            end
            if (WE && (Addr[3:2] == REG_CTRL)) begin
                tx_en  <= Din[0];
                irq_en <= Din[1];
                if (Din[2]) begin
                    overflow <= 1'b0;
                end
            end
            if (wr_data && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            bit_div <= 16'(DIV_RESET);
            txd     <= 1'b1;
        end else begin
            // txd follows the state one cycle later, giving exactly bit_div cycles per bit.
            txd <= (state == ST_START) ? 1'b0 :
                   (state == ST_DATA)  ? shift[0] : 1'b1;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shift   <= fifo_dout;
                        bit_div <= divisor;
                        bit_cnt <= 16'd0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        bit_cnt <= 16'd0;
                        bit_idx <= 3'd0;
                        state   <= ST_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= 16'd0;
                        shift   <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        bit_cnt <= 16'd0;
                        if (pop) begin
                            shift   <= fifo_dout;
                            bit_div <= divisor;
                            state   <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IRQ <= 1'b0;
        end else begin
            IRQ <= irq_en && empty && !busy;
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            REG_STATUS: begin
                Dout[STAT_BUSY]                    = busy;
                Dout[STAT_FULL]                    = full;
                Dout[STAT_EMPTY]                   = empty;
                Dout[STAT_OVF]                     = overflow;
                Dout[STAT_CNT_LSB+3:STAT_CNT_LSB]  = sat_count(32'(count));
            end
            REG_DIVISOR: Dout[15:0] = divisor;
            REG_CTRL:    Dout[1:0]  = {irq_en, tx_en};
            default:     Dout       = 32'd0;
        endcase
    end

endmodule
